isolde_imm_collector: RTL and testbench
=======================================

ISOLDE_IMM_COLLECTOR -- requirements
Module: isolde_imm_collector

Interface
REQ-001 SHALL have parameter IMM32_OPS, default 4, meaning the number of 32-bit immediate slots per custom instruction bundle.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port fetch_valid_i  input  1  fetch word valid.
REQ-005 SHALL have port fetch_word_i  input  32  instruction or immediate word from fetch.
REQ-006 SHALL have port fetch_ready_o  output  1  collector accepts the word this cycle.
REQ-007 SHALL have port flush_i  input  1  abort the current bundle (branch/exception).
REQ-008 SHALL have port exec_ready_i  input  1  execute stage consumes the bundle; low means the decoder is stalled.
REQ-009 SHALL have port dec_enable_o  output  1  bundle valid towards execute.
REQ-010 SHALL have port dec_illegal_o  output  1  bundle carries an unsupported custom instruction.
REQ-011 SHALL have port dec_instr_o  output  32  captured instruction word.
REQ-012 SHALL have ports dec_func3_o  output  3  (instr[14:12]) and dec_funct2_o  output  2  (instr[26:25]).
REQ-013 SHALL have port dec_imm32_o  output  IMM32_OPS x 32  immediate operands, slot 0 first.
REQ-014 SHALL have port dec_imm32_valid_o  output  IMM32_OPS  per-slot valid bits.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL be a three-state FSM: IDLE, COLLECT, ISSUE.
REQ-017 SHALL drive fetch_ready_o high in IDLE and COLLECT and low in ISSUE; a word is accepted only when fetch_valid_i and fetch_ready_o are both high.
REQ-018 In IDLE, an accepted word SHALL be captured as the instruction; the immediate count N is the value of instr[26:25] (0..3).
REQ-019 An instruction SHALL be illegal if instr[6:0] is neither 7'h0B nor 7'h2B, if func3 is 3'b111, or if N > IMM32_OPS.
REQ-020 Illegal instructions, or those with N==0, SHALL go IDLE->ISSUE; all others SHALL go IDLE->COLLECT with slot counter 0.
REQ-021 In COLLECT, each accepted word SHALL be written to slot[cnt] with valid bit cnt set, and cnt SHALL increment; the word with cnt==N-1 SHALL cause COLLECT->ISSUE.
REQ-022 In ISSUE, dec_enable_o SHALL be 1 and all dec_* outputs SHALL be held stable until exec_ready_i is high, then ISSUE->IDLE.
REQ-023 dec_enable_o SHALL rise on the cycle after the last word of a bundle is accepted; back-to-back bundles SHALL have one IDLE cycle between them.
REQ-024 Unused immediate slots SHALL read 32'h0 with valid bits 0; valid bits and slots SHALL clear on ISSUE->IDLE.
REQ-025 flush_i SHALL force IDLE from any state on the next edge, clear all valid bits and the counter, and override a simultaneous accept or exec_ready_i.
REQ-026 dec_illegal_o SHALL be meaningful only while dec_enable_o is high and 0 otherwise.

Reset
REQ-027 On a clock edge with rst_ni low, the block SHALL enter IDLE, and all outputs except fetch_ready_o SHALL be 0, including mid-bundle; fetch_ready_o SHALL be 0 during reset and 1 on the first cycle after release.

Configuration
REQ-028 With ISOLDE_IMM_PERF_EN defined, the block SHALL add output stall_cnt_o (16 bits), which counts cycles in ISSUE with exec_ready_i low, saturates at 16'hFFFF, and is cleared only by reset.
REQ-029 Without ISOLDE_IMM_PERF_EN, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The FSM state enum, the custom opcode constants 7'h0B and 7'h2B, and the reserved func3 value SHALL live in isolde_decoder_pkg.
REQ-031 The saturating counter SHALL be a sub-module, isolde_sat_counter, instantiated only under ISOLDE_IMM_PERF_EN; all other logic SHALL be flat.

Verification
REQ-032 Instr 32'h0200_000B (N=1), then word 32'hDEAD_BEEF, with exec_ready_i=1 -> enable for 1 cycle, imm[0]=DEADBEEF, valid=4'b0001.
REQ-033 Instr 32'h0600_100B (N=3) with 3 words, fetch_valid_i gapped every other cycle -> valid=4'b0111, enable the cycle after the 3rd word.
REQ-034 N=0 custom instr, exec_ready_i low for 5 cycles -> outputs held, fetch_ready_o=0 for 5 cycles, stall_cnt_o=5 when the macro is on.
REQ-035 Word 32'h0000_0013 (non-custom) -> ISSUE on the next cycle with dec_illegal_o=1 and valid=0.
REQ-036 flush_i during the 2nd immediate of an N=3 instr -> IDLE next cycle, valid=0, the next word is captured as an instruction.
REQ-037 rst_ni low mid-COLLECT -> IDLE, dec_enable_o=0, valid=0 after one edge.

Source files
------------

// File: rtl/isolde_decoder_pkg.sv
// Shared decode constants and FSM state type for the custom-instruction immediate collector.
package isolde_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_e;

    localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
    localparam logic [2:0] FUNC3_RSVD  = 3'b111;

    function automatic logic is_custom_opc(input logic [6:0] opc);
        return (opc == OPC_CUSTOM0) || (opc == OPC_CUSTOM1);
    endfunction

endpackage

// File: rtl/isolde_sat_counter.sv
// Purpose: saturating event counter, cleared only by reset.
// Latency: count visible the cycle after the increment edge.
// Backpressure: none; holds at all-ones once saturated.
module isolde_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/isolde_imm_collector.sv
// Purpose: gathers a custom instruction plus its N 32-bit immediates into one decode bundle (ISOLDE_IMM_PERF_EN adds stall_cnt_o).
// Latency: dec_enable_o rises the cycle after the last word of a bundle is accepted.
// Backpressure: fetch_ready_o drops while a bundle waits in ISSUE for exec_ready_i.
module isolde_imm_collector
    import isolde_decoder_pkg::*;
#(
    parameter int IMM32_OPS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fetch_valid_i,
    input  logic [31:0]                fetch_word_i,
    output logic                       fetch_ready_o,
    input  logic                       flush_i,
    input  logic                       exec_ready_i,
    output logic                       dec_enable_o,
    output logic                       dec_illegal_o,
    output logic [31:0]                dec_instr_o,
    output logic [2:0]                 dec_func3_o,
    output logic [1:0]                 dec_funct2_o,
    output logic [IMM32_OPS-1:0][31:0] dec_imm32_o,
    output logic [IMM32_OPS-1:0]       dec_imm32_valid_o,
    output logic                       busy_o
`ifdef ISOLDE_IMM_PERF_EN
    ,
    output logic [15:0]                stall_cnt_o
`endif
);

    state_e                     state_q, state_d;
    logic [31:0]                instr_q;
    logic [1:0]                 n_q;
    logic [1:0]                 cnt_q;
    logic [IMM32_OPS-1:0][31:0] imm_q;
    logic [IMM32_OPS-1:0]       vld_q;
    logic                       illegal_q;

    logic       accept;
    logic [1:0] word_n;
    logic       word_illegal;
    logic       last_imm;

    assign accept       = fetch_valid_i && fetch_ready_o;
    assign word_n       = fetch_word_i[26:25];
    assign word_illegal = !is_custom_opc(fetch_word_i[6:0])
                       || (fetch_word_i[14:12] == FUNC3_RSVD)
                       || (int'(word_n) > IMM32_OPS);
    assign last_imm     = (cnt_q == (n_q - 2'd1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is gated by reset so fetch sees no acceptance while reset is held.
    always_comb begin
        state_d       = state_q;
        fetch_ready_o = 1'b0;
        dec_enable_o  = 1'b0;
        busy_o        = 1'b0;
        case (state_q)
            IDLE: begin
                fetch_ready_o = rst_ni;
                if (accept) begin
                    state_d = (word_illegal || (word_n == 2'd0)) ? ISSUE : COLLECT;
                end
            end
            COLLECT: begin
                fetch_ready_o = rst_ni;
                busy_o        = 1'b1;
                if (accept && last_imm) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dec_enable_o = 1'b1;
                busy_o       = 1'b1;
                if (exec_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q   <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            imm_q     <= '0;
            vld_q     <= '0;
            illegal_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q     <= '0;
            imm_q     <= '0;
            vld_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        instr_q   <= fetch_word_i;
                        n_q       <= word_n;
                        cnt_q     <= '0;
                        illegal_q <= word_illegal;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < IMM32_OPS; i++) begin
                            if (int'(cnt_q) == i) begin
                                imm_q[i] <= fetch_word_i;
                                vld_q[i] <= 1'b1;
                            end
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ISSUE: begin
                    if (exec_ready_i) begin
                        cnt_q     <= '0;
                        imm_q     <= '0;
                        vld_q     <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dec_instr_o       = instr_q;
    assign dec_func3_o       = instr_q[14:12];
    assign dec_funct2_o      = instr_q[26:25];
    assign dec_imm32_o       = imm_q;
    assign dec_imm32_valid_o = vld_q;
    assign dec_illegal_o     = dec_enable_o && illegal_q;

`ifdef ISOLDE_IMM_PERF_EN
    isolde_sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  ((state_q == ISSUE) && !exec_ready_i),
        .cnt_o  (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_isolde_imm_collector.sv
// Directed bench for isolde_imm_collector: bundle capture, gapped fetch, stall, illegal, flush and mid-bundle reset.
module tb_isolde_imm_collector;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             fetch_valid_i;
    logic [31:0]      fetch_word_i;
    logic             fetch_ready_o;
    logic             flush_i;
    logic             exec_ready_i;
    logic             dec_enable_o;
    logic             dec_illegal_o;
    logic [31:0]      dec_instr_o;
    logic [2:0]       dec_func3_o;
    logic [1:0]       dec_funct2_o;
    logic [3:0][31:0] dec_imm32_o;
    logic [3:0]       dec_imm32_valid_o;
    logic             busy_o;
`ifdef ISOLDE_IMM_PERF_EN
    logic [15:0]      stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    isolde_imm_collector #(
        .IMM32_OPS (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_word_i      (fetch_word_i),
        .fetch_ready_o     (fetch_ready_o),
        .flush_i           (flush_i),
        .exec_ready_i      (exec_ready_i),
        .dec_enable_o      (dec_enable_o),
        .dec_illegal_o     (dec_illegal_o),
        .dec_instr_o       (dec_instr_o),
        .dec_func3_o       (dec_func3_o),
        .dec_funct2_o      (dec_funct2_o),
        .dec_imm32_o       (dec_imm32_o),
        .dec_imm32_valid_o (dec_imm32_valid_o),
        .busy_o            (busy_o)
`ifdef ISOLDE_IMM_PERF_EN
        ,
        .stall_cnt_o       (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 2 time units after it.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rst_ni        = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_word_i  = '0;
        flush_i       = 1'b0;
        exec_ready_i  = 1'b1;

        // Reset state
        #1;
        check("rst_ready_low", fetch_ready_o, 0);
        step();
        step();
        check("rst_enable", dec_enable_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_valid", dec_imm32_valid_o, 0);
        check("rst_instr", dec_instr_o, 0);
        check("rst_imm", dec_imm32_o, 0);
        rst_ni = 1'b1;
        #1;
        check("rel_ready_high", fetch_ready_o, 1);

        // N=1 bundle with exec ready
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0200_000B;
        step();
        check("n1_busy", busy_o, 1);
        check("n1_no_enable_yet", dec_enable_o, 0);
        fetch_word_i = 32'hDEAD_BEEF;
        step();
        fetch_valid_i = 1'b0;
        check("n1_enable", dec_enable_o, 1);
        check("n1_imm0", dec_imm32_o[0], 32'hDEAD_BEEF);
        check("n1_valid", dec_imm32_valid_o, 4'b0001);
        check("n1_illegal", dec_illegal_o, 0);
        check("n1_ready_low", fetch_ready_o, 0);
        check("n1_instr", dec_instr_o, 32'h0200_000B);
        check("n1_funct2", dec_funct2_o, 2'd1);
        step();
        check("n1_enable_drop", dec_enable_o, 0);
        check("n1_valid_clr", dec_imm32_valid_o, 0);
        check("n1_imm_clr", dec_imm32_o, 0);

        // N=3 bundle with gapped fetch
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0600_100B;
        step();
        fetch_valid_i = 1'b0;
        step();
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h1111_1111;
        step();
        fetch_valid_i = 1'b0;
        step();
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h2222_2222;
        step();
        fetch_valid_i = 1'b0;
        step();
        check("n3_gap_no_enable", dec_enable_o, 0);
        check("n3_gap_ready", fetch_ready_o, 1);
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h3333_3333;
        step();
        fetch_valid_i = 1'b0;
        check("n3_enable", dec_enable_o, 1);
        check("n3_valid", dec_imm32_valid_o, 4'b0111);
        check("n3_imm0", dec_imm32_o[0], 32'h1111_1111);
        check("n3_imm1", dec_imm32_o[1], 32'h2222_2222);
        check("n3_imm2", dec_imm32_o[2], 32'h3333_3333);
        check("n3_imm3", dec_imm32_o[3], 0);
        check("n3_func3", dec_func3_o, 3'd1);
        check("n3_funct2", dec_funct2_o, 2'd3);
        step();
        check("n3_idle", busy_o, 0);

        // N=0 custom instruction, execute stalled for 5 cycles
        exec_ready_i  = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0000_002B;
        step();
        fetch_valid_i = 1'b0;
        fetch_word_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check("n0_stall_enable", dec_enable_o, 1);
            check("n0_stall_ready", fetch_ready_o, 0);
            check("n0_stall_instr", dec_instr_o, 32'h0000_002B);
            check("n0_stall_valid", dec_imm32_valid_o, 0);
            step();
        end
        exec_ready_i = 1'b1;
        check("n0_still_enable", dec_enable_o, 1);
        step();
        check("n0_released", dec_enable_o, 0);
`ifdef ISOLDE_IMM_PERF_EN
        check("n0_stall_cnt", stall_cnt_o, 16'd5);
`endif

        // Non-custom opcode is illegal and goes straight to ISSUE
        exec_ready_i  = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0000_0013;
        step();
        fetch_valid_i = 1'b0;
        check("ill_enable", dec_enable_o, 1);
        check("ill_flag", dec_illegal_o, 1);
        check("ill_valid", dec_imm32_valid_o, 0);
        exec_ready_i = 1'b1;
        step();
        check("ill_flag_clr", dec_illegal_o, 0);

        // Reserved func3 is illegal even with a custom opcode
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0200_700B;
        step();
        fetch_valid_i = 1'b0;
        check("rsvd_enable", dec_enable_o, 1);
        check("rsvd_illegal", dec_illegal_o, 1);
        step();

        // Flush during the 2nd immediate of an N=3 bundle
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0600_100B;
        step();
        fetch_word_i = 32'hAAAA_0001;
        step();
        fetch_word_i = 32'hAAAA_0002;
        flush_i      = 1'b1;
        step();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        check("fl_idle", busy_o, 0);
        check("fl_valid", dec_imm32_valid_o, 0);
        check("fl_enable", dec_enable_o, 0);
        check("fl_ready", fetch_ready_o, 1);
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0200_000B;
        step();
        check("fl_new_instr", dec_instr_o, 32'h0200_000B);
        check("fl_collect", busy_o, 1);
        fetch_word_i = 32'h1234_5678;
        step();
        fetch_valid_i = 1'b0;
        check("fl_bundle_imm0", dec_imm32_o[0], 32'h1234_5678);
        check("fl_bundle_imm1", dec_imm32_o[1], 0);
        check("fl_bundle_valid", dec_imm32_valid_o, 4'b0001);
        step();

        // Reset asserted mid-COLLECT
        fetch_valid_i = 1'b1;
        fetch_word_i  = 32'h0600_100B;
        step();
        fetch_word_i = 32'hBBBB_0001;
        step();
        check("mr_collecting", dec_imm32_valid_o, 4'b0001);
        rst_ni = 1'b0;
        step();
        check("mr_enable", dec_enable_o, 0);
        check("mr_valid", dec_imm32_valid_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_ready", fetch_ready_o, 0);
        check("mr_instr", dec_instr_o, 0);
        fetch_valid_i = 1'b0;
        rst_ni        = 1'b1;
        #1;
        check("mr_ready_after", fetch_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
